// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, status bundle and address-width helper for prog_fifo
package fifo_pkg;

    localparam int FIFO_DEFAULT_DEPTH = 32;
    localparam int FIFO_DEFAULT_WIDTH = 8;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    // Pointer width for an arbitrary depth; a 1-bit pointer is kept even for tiny memories.
    function automatic int fifo_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH simple dual-port RAM, synchronous write, asynchronous read
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEFAULT_DEPTH,
    parameter int WIDTH = FIFO_DEFAULT_WIDTH,
    parameter int AW    = fifo_addr_width(FIFO_DEFAULT_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fifo.sv
// rtl/prog_fifo.sv - single-clock FIFO with programmable thresholds, count, sticky errors, flush
// Define FIFO_FWFT_EN for first-word fall-through reads; undefined gives a registered read port.
module prog_fifo
    import fifo_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEFAULT_DEPTH,
    parameter  int WIDTH = FIFO_DEFAULT_WIDTH,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             read_valid,
    input  logic [CW-1:0]    af_level,
    input  logic [CW-1:0]    ae_level,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int             AW       = fifo_addr_width(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [AW-1:0]  LAST_PTR = AW'(DEPTH - 1);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf_q;
    logic             udf_q;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] head_data;
    fifo_status_t     status;

    // Explicit wrap so any depth works, not just powers of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        status              = '0;
        status.full         = (cnt == FULL_CNT);
        status.empty        = (cnt == '0);
        status.almost_full  = (cnt >= af_level);
        status.almost_empty = (cnt <= ae_level);
        status.overflow     = ovf_q;
        status.underflow    = udf_q;
    end

    assign wr_acc = write_en & ~status.full;
    assign rd_acc = read_en & ~status.empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (write_en && status.full) begin
                ovf_q <= 1'b1;
            end
            if (read_en && status.empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr),
        .wdata (write_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

`ifdef FIFO_FWFT_EN
    // Head entry is presented directly; zero is shown while empty so stale RAM never leaks out.
    assign read_data  = status.empty ? '0 : head_data;
    assign read_valid = ~status.empty;
`else
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= head_data;
            end
        end
    end

    assign read_data  = rd_data_q;
    assign read_valid = rd_valid_q;
`endif

    assign count        = cnt;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

endmodule

// File: tb/tb_prog_fifo.sv
// tb/tb_prog_fifo.sv - self-checking bench for prog_fifo at DEPTH=32 and DEPTH=5
module tb_prog_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic [5:0] af32 = 6'd28;
    logic [5:0] ae32 = 6'd4;
    logic [2:0] af5 = 3'd4;
    logic [2:0] ae5 = 3'd1;

    logic [7:0] rd_a, rd_b;
    logic       rv_a, rv_b;
    logic [5:0] cnt_a;
    logic [2:0] cnt_b;
    logic       full_a, empty_a, afl_a, ael_a, ovf_a, udf_a;
    logic       full_b, empty_b, afl_b, ael_b, ovf_b, udf_b;

    int errors = 0;
    int checks = 0;

    prog_fifo #(.DEPTH(32), .WIDTH(8)) u_d32 (
        .clk(clk), .reset(reset), .flush(flush),
        .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd_a), .read_valid(rv_a),
        .af_level(af32), .ae_level(ae32), .count(cnt_a),
        .full(full_a), .empty(empty_a), .almost_full(afl_a), .almost_empty(ael_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    prog_fifo #(.DEPTH(5), .WIDTH(8)) u_d5 (
        .clk(clk), .reset(reset), .flush(flush),
        .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd_b), .read_valid(rv_b),
        .af_level(af5), .ae_level(ae5), .count(cnt_b),
        .full(full_b), .empty(empty_b), .almost_full(afl_b), .almost_empty(ael_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    initial forever #5 clk = ~clk;

    // Reference model: one queue per instance plus sticky bits and the last popped word.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_ov[2];
    bit         m_un[2];
    bit         m_rv[2];
    logic [7:0] m_rd[2];

    function automatic int msize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int mdepth(input int k);
        return (k == 0) ? 32 : 5;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = 0; m_un[k] = 0; m_rv[k] = 0; m_rd[k] = 8'h00;
        end
    endtask

    task automatic model_edge(input int k, input bit we, input logic [7:0] wd,
                              input bit re, input bit fl);
        int sz;
        bit wa, ra;
        logic [7:0] h;
        sz = msize(k);
        if (fl) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_ov[k] = 0; m_un[k] = 0; m_rv[k] = 0;
        end else begin
            wa = we && (sz < mdepth(k));
            ra = re && (sz > 0);
            if (we && !wa) m_ov[k] = 1;
            if (re && !ra) m_un[k] = 1;
            m_rv[k] = ra;
            if (ra) begin
                if (k == 0) h = q0.pop_front(); else h = q1.pop_front();
                m_rd[k] = h;
            end
            if (wa) begin
                if (k == 0) q0.push_back(wd); else q1.push_back(wd);
            end
        end
    endtask

    task automatic cmp_model(input int k, input string tag);
        int sz, af, ae, erd, erv;
        string p;
        sz = msize(k);
        af = (k == 0) ? int'(af32) : int'(af5);
        ae = (k == 0) ? int'(ae32) : int'(ae5);
`ifdef FIFO_FWFT_EN
        erv = (sz != 0);
        erd = (sz == 0) ? 0 : ((k == 0) ? int'(q0[0]) : int'(q1[0]));
`else
        erv = m_rv[k];
        erd = m_rd[k];
`endif
        p = {tag, (k == 0) ? "/d32." : "/d5."};
        if (k == 0) begin
            check({p, "count"}, cnt_a, sz);
            check({p, "full"}, full_a, sz == 32);
            check({p, "empty"}, empty_a, sz == 0);
            check({p, "afull"}, afl_a, sz >= af);
            check({p, "aempty"}, ael_a, sz <= ae);
            check({p, "ovf"}, ovf_a, m_ov[0]);
            check({p, "udf"}, udf_a, m_un[0]);
            check({p, "rvalid"}, rv_a, erv);
            check({p, "rdata"}, rd_a, erd);
        end else begin
            check({p, "count"}, cnt_b, sz);
            check({p, "full"}, full_b, sz == 5);
            check({p, "empty"}, empty_b, sz == 0);
            check({p, "afull"}, afl_b, sz >= af);
            check({p, "aempty"}, ael_b, sz <= ae);
            check({p, "ovf"}, ovf_b, m_ov[1]);
            check({p, "udf"}, udf_b, m_un[1]);
            check({p, "rvalid"}, rv_b, erv);
            check({p, "rdata"}, rd_b, erd);
        end
    endtask

    task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit fl,
                       input string tag);
        write_en = we; write_data = wd; read_en = re; flush = fl;
        model_edge(0, we, wd, re, fl);
        model_edge(1, we, wd, re, fl);
        @(posedge clk);
        #1;
        cmp_model(0, tag);
        cmp_model(1, tag);
    endtask

    typedef struct {
        bit         we;
        logic [7:0] wd;
        bit         re;
        int         cnt;
        bit         ae;
        bit         em;
        bit         rv;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 8'h01, 0, 1, 1, 0, 0, 8'h00};
        tbl[1]  = '{1, 8'h02, 0, 2, 1, 0, 0, 8'h00};
        tbl[2]  = '{1, 8'h03, 0, 3, 1, 0, 0, 8'h00};
        tbl[3]  = '{1, 8'h04, 0, 4, 1, 0, 0, 8'h00};
        tbl[4]  = '{1, 8'h05, 0, 5, 0, 0, 0, 8'h00};
        tbl[5]  = '{0, 8'h00, 1, 4, 1, 0, 1, 8'h01};
        tbl[6]  = '{0, 8'h00, 1, 3, 1, 0, 1, 8'h02};
        tbl[7]  = '{0, 8'h00, 1, 2, 1, 0, 1, 8'h03};
        tbl[8]  = '{0, 8'h00, 1, 1, 1, 0, 1, 8'h04};
        tbl[9]  = '{0, 8'h00, 1, 0, 1, 1, 1, 8'h05};
        tbl[10] = '{0, 8'h00, 0, 0, 1, 1, 0, 8'h05};

        model_reset();

        // Reset state, observed while reset is still asserted
        #11;
        check("rst.count", cnt_a, 0);
        check("rst.empty", empty_a, 1);
        check("rst.aempty", ael_a, 1);
        check("rst.full", full_a, 0);
        check("rst.afull", afl_a, 0);
        check("rst.rdata", rd_a, 0);
        check("rst.rvalid", rv_a, 0);
        check("rst.ovf", ovf_a, 0);
        check("rst.udf", udf_a, 0);
        check("rst.d5.count", cnt_b, 0);
        #1 reset = 1'b1;

        // Five writes then five reads, vectors from the table
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].we, tbl[i].wd, tbl[i].re, 0, "t2");
            check("t2.count", cnt_a, tbl[i].cnt);
            check("t2.aempty", ael_a, tbl[i].ae);
            check("t2.empty", empty_a, tbl[i].em);
`ifndef FIFO_FWFT_EN
            check("t2.rvalid", rv_a, tbl[i].rv);
            check("t2.rdata", rd_a, tbl[i].rd);
`endif
        end

        // Fill past full: almost_full at 28, full at 32, 33rd write dropped
        for (int i = 0; i < 33; i++) begin
            cyc(1, 8'(8'h11 + i), 0, 0, "t3w");
            if (i == 26) check("t3.afull_at27", afl_a, 0);
            if (i == 27) check("t3.afull_at28", afl_a, 1);
            if (i == 30) check("t3.full_at31", full_a, 0);
            if (i == 31) check("t3.full_at32", full_a, 1);
            if (i == 31) check("t3.ovf_before", ovf_a, 0);
        end
        check("t3.ovf", ovf_a, 1);
        check("t3.count", cnt_a, 32);
        for (int i = 0; i < 32; i++) begin
`ifdef FIFO_FWFT_EN
            check("t3.head", rd_a, 8'h11 + i);
            check("t3.rvalid", rv_a, 1);
            cyc(0, 8'h00, 1, 0, "t3r");
`else
            cyc(0, 8'h00, 1, 0, "t3r");
            check("t3.rdata", rd_a, 8'h11 + i);
`endif
        end
        check("t3.empty", empty_a, 1);

        // Underflow on empty, cleared by flush
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, "t4");
        check("t4.count", cnt_a, 0);
        check("t4.udf", udf_a, 1);
        cyc(0, 8'h00, 0, 1, "t4f");
        check("t4.udf_flushed", udf_a, 0);
        check("t4.ovf_flushed", ovf_a, 0);

        // Simultaneous read and write
        for (int i = 0; i < 10; i++) cyc(1, 8'(8'h40 + i), 0, 0, "t5w");
        for (int i = 0; i < 4; i++) cyc(1, 8'(8'h50 + i), 1, 0, "t5rw");
        check("t5.count_hold", cnt_a, 10);
        for (int i = 0; i < 22; i++) cyc(1, 8'(8'h60 + i), 0, 0, "t5f");
        check("t5.full", full_a, 1);
        cyc(1, 8'hEE, 1, 0, "t5full_rw");
        check("t5.count31", cnt_a, 31);
        check("t5.ovf", ovf_a, 1);
        cyc(0, 8'h00, 0, 1, "t5flush");

        // Non-power-of-2 depth: three rounds through the DEPTH=5 instance
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + r * 16 + i), 0, 0, "t6w");
            for (int i = 0; i < 4; i++) begin
`ifdef FIFO_FWFT_EN
                check("t6.head", rd_b, 8'hA0 + r * 16 + i);
                check("t6.rvalid", rv_b, 1);
                cyc(0, 8'h00, 1, 0, "t6r");
`else
                cyc(0, 8'h00, 1, 0, "t6r");
                check("t6.rdata", rd_b, 8'hA0 + r * 16 + i);
`endif
            end
        end
        check("t6.empty", empty_b, 1);

        // Randomized traffic with alternating fill/drain bias and threshold changes
        for (int i = 0; i < 800; i++) begin
            bit we, re, fl;
            int bias;
            if (i % 150 == 0) begin
                af32 = 6'($urandom_range(0, 32));
                ae32 = 6'($urandom_range(0, 32));
                af5  = 3'($urandom_range(0, 5));
                ae5  = 3'($urandom_range(0, 5));
            end
            bias = ((i / 100) % 2 == 0) ? 75 : 25;
            we = ($urandom_range(0, 99) < bias);
            re = ($urandom_range(0, 99) < (100 - bias));
            fl = ($urandom_range(0, 249) == 0);
            cyc(we, 8'($urandom), re, fl, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
